vram_port_arbiter: RTL

- Shares the single SDRAM/VRAM FIFO port between NUM_REQ requesters, for example the falling-piece block writer and the row-scan/line-clear reader.
- The port consists of write_ld/write_req/writeaddr/writedata, read_ld/read_req/readaddr, and the wr_buffer/rd_buffer/readdata returns.
- Round-robin, lock-until-release grants. The write FIFO is drained before any ownership change, and a hold watchdog bounds how long one owner can keep the port.
- Sits between the game-logic requesters and the SDRAM FIFO controller.

---
 rtl/vram_pkg.sv | 19 +
 rtl/rr_pick.sv | 27 ++
 rtl/vram_port_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared SDRAM/VRAM definitions for the board renderer and its port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vram_pkg;

    localparam int VRAM_ADDR_W = 25;
    localparam int VRAM_DATA_W = 16;

    // Words per board row; the row-scan reader walks the board in these units.
    localparam int ROW_WORDS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2,
        TURN  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first requesting index searching upward from last+1, with wrap.
// Latency: purely combinational.
// Backpressure: none; vld is low when no request is present.
module rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic [1:0]         idx,
    output logic               vld
);

    // Walk candidates from farthest to nearest so the nearest to last+1 wins.
    always_comb begin
        int cand;
        cand = 0;
        idx  = '0;
        vld  = |req;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = (int'(last) + i) % NUM_REQ;
            if (req[cand]) begin
                idx = 2'(cand);
            end
        end
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares one SDRAM FIFO port between NUM_REQ requesters, round-robin with lock-until-release.
// Latency: grant 1 cycle after req in IDLE; release-to-regrant 2+TURN_CYC cycles with an empty write FIFO.
// Backpressure: ownership changes wait for wr_buffer==0; a watchdog revokes an owner hogging the port.
module vram_port_arbiter
    import vram_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int DATA_W   = VRAM_DATA_W,
    parameter int HOLD_MAX = 4096,
    parameter int TURN_CYC = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        revoke,
    input  logic [NUM_REQ-1:0]        m_write_ld,
    input  logic [NUM_REQ-1:0]        m_write_req,
    input  logic [NUM_REQ*ADDR_W-1:0] m_writeaddr,
    input  logic [NUM_REQ*DATA_W-1:0] m_writedata,
    input  logic [NUM_REQ-1:0]        m_read_ld,
    input  logic [NUM_REQ-1:0]        m_read_req,
    input  logic [NUM_REQ*ADDR_W-1:0] m_readaddr,
    output logic                      write_ld,
    output logic                      write_req,
    output logic                      read_ld,
    output logic                      read_req,
    output logic [ADDR_W-1:0]         writeaddr,
    output logic [ADDR_W-1:0]         readaddr,
    output logic [DATA_W-1:0]         writedata,
    input  logic [15:0]               wr_buffer,
    input  logic [15:0]               rd_buffer,
    output logic                      busy,
    output logic [1:0]                owner,
    output logic                      timeout_flag
);

    localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    arb_state_t          state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [1:0]          turn_cnt;
    logic [1:0]          pick_idx;
    logic                pick_vld;
    logic [NUM_REQ-1:0]  owner_oh;
    logic [NUM_REQ-1:0]  pick_oh;
    logic                owner_req;
    logic                others_pending;

    // Read-side fill level is the reader's business; the arbiter only drains writes.
    logic                unused_rd_buffer;
    assign unused_rd_buffer = ^rd_buffer;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req  (req),
        .last (owner),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    assign owner_oh       = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
    assign pick_oh        = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
    assign owner_req      = |(req & owner_oh);
    assign others_pending = |(req & ~owner_oh);
    assign busy           = (state != IDLE);

    // Arbitration FSM: grant, hold watchdog, write-FIFO drain, then turnaround gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= '0;
            revoke       <= '0;
            owner        <= 2'(NUM_REQ-1);
            hold_cnt     <= '0;
            turn_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            revoke <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant    <= pick_oh;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // A voluntary release outranks a watchdog expiry on the same edge.
                    if (!owner_req) begin
                        grant    <= '0;
                        hold_cnt <= '0;
                        state    <= DRAIN;
                    end else if (others_pending) begin
                        if (hold_cnt == HOLD_W'(HOLD_MAX-1)) begin
                            revoke       <= owner_oh;
                            grant        <= '0;
                            timeout_flag <= 1'b1;
                            hold_cnt     <= '0;
                            state        <= DRAIN;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else begin
                        hold_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (wr_buffer == 16'd0) begin
                        turn_cnt <= '0;
                        state    <= TURN;
                    end
                end
                TURN: begin
                    // The edge leaving TURN arbitrates like IDLE so a waiting requester loses no cycle.
                    if (turn_cnt == 2'(TURN_CYC-1)) begin
                        if (pick_vld) begin
                            grant    <= pick_oh;
                            owner    <= pick_idx;
                            hold_cnt <= '0;
                            state    <= GRANT;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port mux: AND-OR select on the registered grant, so no grant means all-zero outputs.
    always_comb begin
        write_ld  = 1'b0;
        write_req = 1'b0;
        read_ld   = 1'b0;
        read_req  = 1'b0;
        writeaddr = '0;
        readaddr  = '0;
        writedata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                write_ld  = m_write_ld[i];
                write_req = m_write_req[i];
                read_ld   = m_read_ld[i];
                read_req  = m_read_req[i];
                writeaddr = m_writeaddr[i*ADDR_W +: ADDR_W];
                readaddr  = m_readaddr[i*ADDR_W +: ADDR_W];
                writedata = m_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule
